// File: rtl/adder_tree_arbiter.sv
// Round-robin front end for a shared 5-operand pipelined adder tree.
// Requester IDs travel down a valid/tag delay line matched to the tree latency.
module adder_tree_arbiter #(
   parameter int N        = 4,
   parameter int W        = 16,
   parameter int TREE_LAT = 4,
   parameter int IDW      = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               hold,
   input  logic [N-1:0]       req_valid,
   output logic [N-1:0]       req_ready,
   input  logic [N*5*W-1:0]   req_data,
   output logic [W-1:0]       tree_a,
   output logic [W-1:0]       tree_b,
   output logic [W-1:0]       tree_c,
   output logic [W-1:0]       tree_d,
   output logic [W-1:0]       tree_e,
   input  logic [W-1:0]       tree_out,
   output logic               rsp_valid,
   output logic [IDW-1:0]     rsp_id,
   output logic [W-1:0]       rsp_data,
   output logic               busy
);

   localparam int OPW = 5 * W;

   logic [IDW-1:0]                ptr;
   logic [IDW-1:0]                gnt_id;
   logic [IDW-1:0]                idx;
   logic                          gnt_any;
   logic [OPW-1:0]                gnt_data;
   logic [TREE_LAT:0]             vld_pipe;
   logic [TREE_LAT:0][IDW-1:0]    id_pipe;

   // Search starts one past the last winner, so the winner drops to lowest priority.
   always_comb begin
      req_ready = '0;
      gnt_any   = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = IDW'((int'(ptr) + 1 + k) % N);
         if (!hold && !gnt_any && req_valid[idx]) begin
            req_ready[idx] = 1'b1;
            gnt_any        = 1'b1;
            gnt_id         = idx;
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N; i++)
         if (req_ready[i]) gnt_data = gnt_data | req_data[i*OPW +: OPW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= IDW'(N - 1);
         tree_a    <= '0;
         tree_b    <= '0;
         tree_c    <= '0;
         tree_d    <= '0;
         tree_e    <= '0;
         vld_pipe  <= '0;
         id_pipe   <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         busy      <= 1'b0;
      end else begin
         // Operands hold when idle; the tree keeps summing them but the tag is invalid.
         if (gnt_any) begin
            ptr    <= gnt_id;
            tree_a <= gnt_data[0*W +: W];
            tree_b <= gnt_data[1*W +: W];
            tree_c <= gnt_data[2*W +: W];
            tree_d <= gnt_data[3*W +: W];
            tree_e <= gnt_data[4*W +: W];
         end
         vld_pipe  <= {vld_pipe[TREE_LAT-1:0], gnt_any};
         id_pipe   <= {id_pipe[TREE_LAT-1:0], gnt_id};
         rsp_valid <= vld_pipe[TREE_LAT];
         if (vld_pipe[TREE_LAT]) begin
            rsp_id   <= id_pipe[TREE_LAT];
            rsp_data <= tree_out;
         end
         busy <= gnt_any | (|vld_pipe);
      end
   end

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Bench for adder_tree_arbiter: models the 4-stage tree, the round-robin
// grant, and scoreboards every response against the granted operands.
module tb_adder_tree_arbiter;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int TL  = 4;
   localparam int IDW = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               hold = 1'b0;
   logic [N-1:0]       req_valid = '0;
   logic [N-1:0]       req_ready;
   logic [N*5*W-1:0]   req_data = '0;
   logic [W-1:0]       tree_a, tree_b, tree_c, tree_d, tree_e, tree_out;
   logic               rsp_valid;
   logic [IDW-1:0]     rsp_id;
   logic [W-1:0]       rsp_data;
   logic               busy;

   adder_tree_arbiter #(.N(N), .W(W), .TREE_LAT(TL), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .tree_a(tree_a), .tree_b(tree_b), .tree_c(tree_c), .tree_d(tree_d), .tree_e(tree_e),
      .tree_out(tree_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Shared tree: no reset, sum visible TL edges after the operands are sampled.
   logic [W-1:0] ts [TL];
   always @(posedge clk) begin
      ts[0] <= tree_a + tree_b + tree_c + tree_d + tree_e;
      for (int i = 1; i < TL; i++) ts[i] <= ts[i-1];
   end
   assign tree_out = ts[TL-1];

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [W-1:0]   data;
   } exp_t;

   exp_t   q[$];
   exp_t   m_e;
   int     total = 0;
   int     bad = 0;
   int     resp_cnt = 0;
   int     mptr = N - 1;
   int     m_gi;
   logic [IDW-1:0] m_idx;
   logic [N-1:0]   m_eg;
   logic [W-1:0]   m_sum;

   // Monitor: check responses against the queue, then model the grant and push.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         q.delete();
         mptr = N - 1;
      end else begin
         if (rsp_valid) begin
            resp_cnt++;
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected: got id=%0d data=%h, none required", rsp_id, rsp_data);
            end else begin
               m_e = q.pop_front();
               if (rsp_id !== m_e.id || rsp_data !== m_e.data) begin
                  bad++;
                  $display("FAIL rsp_scoreboard: got id=%0d data=%h, required id=%0d data=%h",
                           rsp_id, rsp_data, m_e.id, m_e.data);
               end
            end
         end
         m_eg = '0;
         m_gi = -1;
         if (!hold)
            for (int k = 0; k < N; k++) begin
               m_idx = IDW'((mptr + 1 + k) % N);
               if (m_gi < 0 && req_valid[m_idx]) m_gi = int'(m_idx);
            end
         if (m_gi >= 0) m_eg[m_gi] = 1'b1;
         total++;
         if (req_ready !== m_eg) begin
            bad++;
            $display("FAIL grant_model: got %b, required %b", req_ready, m_eg);
         end
         if (m_gi >= 0) begin
            m_sum = '0;
            for (int f = 0; f < 5; f++) m_sum = m_sum + req_data[m_gi*5*W + f*W +: W];
            q.push_back('{id: IDW'(m_gi), data: m_sum});
            mptr = m_gi;
         end
      end
   end

   task automatic set_ops(input int r, input logic [W-1:0] a, b, c, d, e);
      req_data[r*5*W +: 5*W] = {e, d, c, b, a};
   endtask

   task automatic apply_reset;
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      hold = 1'b0;
      req_data = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      apply_reset();
      #3;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
      total++; if (rsp_id !== '0) begin bad++; $display("FAIL reset_rsp_id: got %0d, required 0", rsp_id); end
      total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data: got %h, required 0", rsp_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
      total++; if ({tree_a, tree_b, tree_c, tree_d, tree_e} !== '0) begin
         bad++; $display("FAIL reset_tree_ops: got %h %h %h %h %h, required 0", tree_a, tree_b, tree_c, tree_d, tree_e);
      end
      total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b, required 0", req_ready); end
   endtask

   task automatic test_single;
      apply_reset();
      set_ops(0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
      req_valid = 4'b0001;
      #3;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b, required 0001", req_ready); end
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         req_valid = '0;
         #3;
         total++;
         if (rsp_valid !== (k == 6)) begin
            bad++; $display("FAIL single_rsp_valid: cycle %0d got %b, required %b", k, rsp_valid, (k == 6));
         end
         if (k == 6) begin
            total++;
            if (rsp_id !== 2'd0 || rsp_data !== 16'd15) begin
               bad++; $display("FAIL single_rsp: got id=%0d data=%0d, required id=0 data=15", rsp_id, rsp_data);
            end
         end
         total++;
         if (busy !== (k <= 6)) begin
            bad++; $display("FAIL single_busy: cycle %0d got %b, required %b", k, busy, (k <= 6));
         end
      end
   endtask

   task automatic test_round_robin;
      logic [N-1:0] eg;
      logic [W-1:0] v;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         v = W'(i + 1);
         set_ops(i, v, v, v, v, v);
      end
      for (int c = 0; c < 16; c++) begin
         req_valid = (c < 8) ? 4'b1111 : 4'b0000;
         #3;
         if (c < 8) begin
            eg = 4'b0001 << (c % 4);
            total++;
            if (req_ready !== eg) begin bad++; $display("FAIL rr_grant: cycle %0d got %b, required %b", c, req_ready, eg); end
         end
         total++;
         if (rsp_valid !== (c >= 6 && c < 14)) begin
            bad++; $display("FAIL rr_rsp_valid: cycle %0d got %b", c, rsp_valid);
         end else if (rsp_valid) begin
            total++;
            if (rsp_id !== IDW'((c - 6) % 4) || rsp_data !== W'(5 * ((c - 6) % 4 + 1))) begin
               bad++; $display("FAIL rr_rsp: cycle %0d got id=%0d data=%0d, required id=%0d data=%0d",
                               c, rsp_id, rsp_data, (c - 6) % 4, 5 * ((c - 6) % 4 + 1));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap;
      apply_reset();
      set_ops(1, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0);
      for (int c = 0; c < 9; c++) begin
         req_valid = (c == 0) ? 4'b0010 : 4'b0000;
         #3;
         if (c == 6) begin
            total++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 16'h0000}) begin
               bad++; $display("FAIL wrap_rsp: got v=%b id=%0d data=%h, required v=1 id=1 data=0000", rsp_valid, rsp_id, rsp_data);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_hold;
      int r0;
      logic exp_v;
      apply_reset();
      set_ops(2, 16'd10, 16'd20, 16'd30, 16'd40, 16'd50);
      r0 = resp_cnt;
      for (int c = 0; c < 18; c++) begin
         req_valid = (c < 10) ? 4'b0100 : 4'b0000;
         hold = (c >= 3 && c <= 5);
         #3;
         if (c < 10) begin
            total++;
            if (req_ready !== (hold ? 4'b0000 : 4'b0100)) begin
               bad++; $display("FAIL hold_grant: cycle %0d got %b, required %b", c, req_ready, hold ? 4'b0000 : 4'b0100);
            end
         end
         exp_v = (c >= 6 && c < 16 && !(c >= 9 && c <= 11));
         total++;
         if (rsp_valid !== exp_v) begin bad++; $display("FAIL hold_rsp_valid: cycle %0d got %b, required %b", c, rsp_valid, exp_v); end
         @(negedge clk);
      end
      hold = 1'b0;
      total++;
      if (resp_cnt - r0 !== 7) begin bad++; $display("FAIL hold_count: got %0d responses, required 7", resp_cnt - r0); end
   endtask

   task automatic test_reset_mid;
      apply_reset();
      set_ops(0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
      for (int c = 0; c < 18; c++) begin
         req_valid = (c < 3) ? 4'b0001 : 4'b0000;
         if (c == 5) rst_n = 1'b0;
         if (c == 6) rst_n = 1'b1;
         #3;
         if (c >= 5) begin
            total++;
            if ({rsp_valid, busy, rsp_id, rsp_data} !== '0) begin
               bad++; $display("FAIL rstmid_quiet: cycle %0d got v=%b busy=%b id=%0d data=%h, required all 0",
                               c, rsp_valid, busy, rsp_id, rsp_data);
            end
         end
         @(negedge clk);
      end
      set_ops(3, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0);
      for (int c = 0; c < 9; c++) begin
         req_valid = (c == 0) ? 4'b1000 : 4'b0000;
         #3;
         if (c == 6) begin
            total++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 16'd7}) begin
               bad++; $display("FAIL rstmid_after: got v=%b id=%0d data=%0d, required v=1 id=3 data=7", rsp_valid, rsp_id, rsp_data);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_fairness;
      logic [N-1:0] eg;
      apply_reset();
      set_ops(0, 16'd100, 16'd0, 16'd0, 16'd0, 16'd1);
      set_ops(3, 16'd300, 16'd0, 16'd0, 16'd0, 16'd3);
      for (int c = 0; c < 16; c++) begin
         req_valid = (c < 8) ? 4'b1001 : 4'b0000;
         #3;
         if (c < 8) begin
            eg = (c % 2 == 0) ? 4'b0001 : 4'b1000;
            total++;
            if (req_ready !== eg) begin bad++; $display("FAIL fair_grant: cycle %0d got %b, required %b", c, req_ready, eg); end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_hold();
      test_reset_mid();
      test_fairness();
      repeat (4) @(negedge clk);
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL drain: %0d responses outstanding, required 0", q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
